// File: rtl/avalon_ram_ws.sv
// avalon_ram_ws
// Avalon-MM 32-bit word RAM model with programmable wait states. Each transfer
// is stalled for a latency L (fixed, or drawn from a 16-bit LFSR). The model
// also raises a sticky bus_error on misaligned or out-of-range accesses, on
// read+write collisions, and when the master abandons a stalled request.

module avalon_ram_ws #(
    parameter string       RAM_INIT_FILE = "",
    parameter logic [31:0] BASE_ADDR     = 32'hBFC00000,
    parameter int          DEPTH_LOG2    = 12,
    parameter int          MODE          = 0,
    parameter int          WAIT_CYCLES   = 0,
    parameter int          MAX_WAIT      = 7,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] address,
    input  logic [3:0]  byteenable,
    input  logic        read,
    input  logic        write,
    output logic        waitrequest,
    output logic [31:0] readdata,
    input  logic [31:0] writedata,
    output logic        bus_error
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Fibonacci LFSR step, taps 16,14,13,11 (bits 15,13,12,10).
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // Latency for a newly accepted request, derived from the current LFSR.
    function automatic logic [15:0] sample_wait(input logic [15:0] v);
        logic [15:0] l;
        if (MODE == 0) begin
            l = 16'(WAIT_CYCLES);
        end else begin
            l = v % 16'(MAX_WAIT + 1);
        end
        return l;
    endfunction

    state_t      state_r;
    state_t      state_nxt_s;
    logic [15:0] cnt_r;
    logic [15:0] cnt_nxt_s;
    logic [15:0] lfsr_r;
    logic        bus_error_r;

    logic        req_s;
    logic [15:0] lat_s;
    logic [31:0] offset_s;
    logic        addr_ok_s;
    logic [DEPTH_LOG2-1:0] index_s;

    logic        waitrequest_s;
    logic        complete_s;
    logic        violation_s;
    logic [31:0] rdata_s;
    logic        err_set_s;
    logic        do_write_s;

    logic [31:0] mem_r [DEPTH];

    // Memory power-up contents: all zero.
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] = 32'h0000_0000;
        end
    end

    assign req_s     = read | write;
    assign lat_s     = sample_wait(lfsr_r);
    // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
    assign offset_s  = address - BASE_ADDR;
    assign addr_ok_s = (offset_s[1:0] == 2'b00) &&
                       (offset_s[31:DEPTH_LOG2+2] == '0);
    assign index_s   = offset_s[DEPTH_LOG2+1:2];

    // State register: IDLE/BUSY with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and next-count logic.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (req_s && (lat_s != 16'd0)) begin
                    state_nxt_s = ST_BUSY;
                    cnt_nxt_s   = lat_s - 16'd1;
                end else begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 16'd0;
                end
            end
            ST_BUSY: begin
                if (!req_s) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 16'd0;
                end else if (cnt_r == 16'd0) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 16'd0;
                end else begin
                    state_nxt_s = ST_BUSY;
                    cnt_nxt_s   = cnt_r - 16'd1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 16'd0;
            end
        endcase
    end

    // Handshake outputs: stall, completion and abandoned-request detection.
    always_comb begin
        waitrequest_s = 1'b1;
        complete_s    = 1'b0;
        violation_s   = 1'b0;
        if (!reset_n) begin
            waitrequest_s = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_s) begin
                        waitrequest_s = (lat_s != 16'd0);
                        complete_s    = (lat_s == 16'd0);
                    end else begin
                        waitrequest_s = 1'b0;
                    end
                end
                ST_BUSY: begin
                    waitrequest_s = (cnt_r != 16'd0);
                    if (!req_s) begin
                        violation_s = 1'b1;
                    end else begin
                        complete_s = (cnt_r == 16'd0);
                    end
                end
                default: begin
                    waitrequest_s = 1'b1;
                end
            endcase
        end
    end

    // Read data is driven only in a valid read completion cycle.
    always_comb begin
        rdata_s = 32'h0000_0000;
        if (complete_s && read && addr_ok_s) begin
            rdata_s = mem_r[index_s];
        end else begin
            rdata_s = 32'h0000_0000;
        end
    end

    // A simultaneous read+write is served as a read, so the write is dropped.
    assign do_write_s = complete_s && write && !read && addr_ok_s;
    assign err_set_s  = violation_s ||
                        (complete_s && ((read && write) || !addr_ok_s));

    // Wait counter, LFSR and sticky error flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r       <= 16'd0;
            lfsr_r      <= LFSR_SEED;
            bus_error_r <= 1'b0;
        end else begin
            cnt_r <= cnt_nxt_s;
            if ((MODE != 0) && (state_r == ST_IDLE) && req_s) begin
                lfsr_r <= lfsr_next(lfsr_r);
            end
            if (err_set_s) begin
                bus_error_r <= 1'b1;
            end
        end
    end

    // Byte-lane write into the RAM array; contents survive reset.
    always_ff @(posedge clk) begin
        if (do_write_s) begin
            for (int i = 0; i < 4; i++) begin
                if (byteenable[i]) begin
                    mem_r[index_s][8*i +: 8] <= writedata[8*i +: 8];
                end
            end
        end
    end

    assign waitrequest = waitrequest_s;
    assign readdata    = rdata_s;
    assign bus_error   = bus_error_r;

endmodule

// File: tb/tb_avalon_ram_ws.sv
// Testbench for avalon_ram_ws: three instances (zero-wait, fixed 3-wait,
// random-wait) driven by directed steps and a randomized scoreboard phase.

module tb_avalon_ram_ws;

    localparam logic [31:0] BASE = 32'hBFC00000;
    localparam int          DL2  = 6;
    localparam int          NW   = 1 << DL2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] address;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        rd_s    [3];
    logic        wr_s    [3];
    logic        wreq_s  [3];
    logic        err_s   [3];
    logic [31:0] rdata_s [3];

    int total = 0;
    int bad   = 0;

    logic [31:0] ref_mem [NW];
    logic [15:0] ref_lfsr;

    always #5 clk = ~clk;

    avalon_ram_ws #(.BASE_ADDR(BASE), .DEPTH_LOG2(DL2), .MODE(0), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
        .read(rd_s[0]), .write(wr_s[0]), .waitrequest(wreq_s[0]),
        .readdata(rdata_s[0]), .writedata(writedata), .bus_error(err_s[0]));

    avalon_ram_ws #(.BASE_ADDR(BASE), .DEPTH_LOG2(DL2), .MODE(0), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
        .read(rd_s[1]), .write(wr_s[1]), .waitrequest(wreq_s[1]),
        .readdata(rdata_s[1]), .writedata(writedata), .bus_error(err_s[1]));

    avalon_ram_ws #(.BASE_ADDR(BASE), .DEPTH_LOG2(DL2), .MODE(1), .MAX_WAIT(7),
                    .LFSR_SEED(16'hACE1)) u_dutr (
        .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
        .read(rd_s[2]), .write(wr_s[2]), .waitrequest(wreq_s[2]),
        .readdata(rdata_s[2]), .writedata(writedata), .bus_error(err_s[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one transfer (entered and left at posedge+1); counts stalled cycles.
    task automatic xfer(input int sel, input bit is_wr, input bit is_rd,
                        input logic [31:0] a, input logic [3:0] be, input logic [31:0] d,
                        output int waits, output logic [31:0] rdata);
        bit done;
        address    = a;
        byteenable = be;
        writedata  = d;
        rd_s[sel]  = is_rd;
        wr_s[sel]  = is_wr;
        waits      = 0;
        rdata      = 32'h0;
        done       = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (wreq_s[sel] === 1'b0) begin
                rdata = rdata_s[sel];
                done  = 1'b1;
            end else begin
                waits++;
                if (waits > 40) begin
                    total++;
                    bad++;
                    $error("FAIL timeout dut=%0d observed=stalled expected=completion", sel);
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < 3; i++) begin
            rd_s[i] = 1'b0;
            wr_s[i] = 1'b0;
        end
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference latency: LFSR value mod (MAX_WAIT+1), then one LFSR step.
    function automatic int ref_wait();
        int w;
        w        = int'(ref_lfsr % 16'd8);
        ref_lfsr = {ref_lfsr[14:0], ^(ref_lfsr & 16'hB400)};
        return w;
    endfunction

    initial begin
        int          w;
        int          ew;
        logic [31:0] r;
        logic [31:0] d;
        logic [3:0]  be;
        int          idx;
        bit          is_rd;
        bit          seen0;
        bit          seen7;

        reset_n    = 1'b0;
        address    = BASE;
        writedata  = 32'h0;
        byteenable = 4'hF;
        for (int i = 0; i < 3; i++) begin
            rd_s[i] = 1'b0;
            wr_s[i] = 1'b0;
        end
        rd_s[0] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wait", 32'(wreq_s[0]), 32'd1);
        chk("rst_rdata", rdata_s[0], 32'h0);
        chk("rst_err0", 32'(err_s[0]), 32'd0);
        chk("rst_err2", 32'(err_s[2]), 32'd0);
        @(posedge clk);
        #1;
        rd_s[0] = 1'b0;
        reset_n = 1'b1;
        idle(1);

        // Zero-wait write and read-back.
        xfer(0, 1'b1, 1'b0, BASE, 4'hF, 32'hDEADBEEF, w, r);
        chk("t1_wr_wait", 32'(w), 32'd0);
        xfer(0, 1'b0, 1'b1, BASE, 4'hF, 32'h0, w, r);
        chk("t1_rd_wait", 32'(w), 32'd0);
        chk("t1_rd_data", r, 32'hDEADBEEF);
        idle(1);

        // Fixed three wait states, back-to-back.
        xfer(1, 1'b1, 1'b0, BASE + 32'd4, 4'hF, 32'h12345678, w, r);
        chk("t2_wr_wait", 32'(w), 32'd3);
        xfer(1, 1'b0, 1'b1, BASE + 32'd4, 4'hF, 32'h0, w, r);
        chk("t2_rd_wait", 32'(w), 32'd3);
        chk("t2_rd_data", r, 32'h12345678);
        xfer(1, 1'b0, 1'b1, BASE + 32'd4, 4'hF, 32'h0, w, r);
        chk("t2_rd2_wait", 32'(w), 32'd3);
        chk("t2_rd2_data", r, 32'h12345678);
        idle(1);

        // Byte lanes.
        xfer(0, 1'b1, 1'b0, BASE + 32'd8, 4'hF, 32'hAAAAAAAA, w, r);
        xfer(0, 1'b1, 1'b0, BASE + 32'd8, 4'b0101, 32'h11223344, w, r);
        xfer(0, 1'b0, 1'b1, BASE + 32'd8, 4'hF, 32'h0, w, r);
        chk("t3_be5_data", r, 32'hAA22AA44);
        xfer(0, 1'b1, 1'b0, BASE + 32'd8, 4'b0000, 32'hFFFFFFFF, w, r);
        chk("t3_be0_wait", 32'(w), 32'd0);
        xfer(0, 1'b0, 1'b1, BASE + 32'd8, 4'hF, 32'h0, w, r);
        chk("t3_be0_data", r, 32'hAA22AA44);
        idle(1);

        // Misaligned and out-of-range accesses.
        chk("t4_err_pre", 32'(err_s[0]), 32'd0);
        xfer(0, 1'b0, 1'b1, BASE + 32'd2, 4'hF, 32'h0, w, r);
        chk("t4_mis_wait", 32'(w), 32'd0);
        chk("t4_mis_data", r, 32'h0);
        idle(1);
        chk("t4_err_set", 32'(err_s[0]), 32'd1);
        xfer(0, 1'b1, 1'b0, BASE + 32'(4 * NW), 4'hF, 32'h55555555, w, r);
        xfer(0, 1'b1, 1'b0, BASE + 32'd1, 4'hF, 32'h00000000, w, r);
        xfer(0, 1'b0, 1'b1, BASE, 4'hF, 32'h0, w, r);
        chk("t4_mem_kept", r, 32'hDEADBEEF);
        idle(3);
        chk("t4_err_sticky", 32'(err_s[0]), 32'd1);

        // Request abandoned while stalled.
        chk("pv_err_pre", 32'(err_s[1]), 32'd0);
        address = BASE + 32'd4;
        rd_s[1] = 1'b1;
        @(posedge clk);
        #1;
        idle(2);
        chk("pv_err_set", 32'(err_s[1]), 32'd1);

        // Reset while BUSY with cnt=2 aborts the write.
        address    = BASE + 32'd4;
        writedata  = 32'hCAFEF00D;
        byteenable = 4'hF;
        wr_s[1]    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t5_busy_wait", 32'(wreq_s[1]), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("t5_rst_wait", 32'(wreq_s[1]), 32'd1);
        chk("t5_rst_rdata", rdata_s[1], 32'h0);
        repeat (2) @(posedge clk);
        #1;
        wr_s[1] = 1'b0;
        reset_n = 1'b1;
        chk("t5_err0_clr", 32'(err_s[0]), 32'd0);
        chk("t5_err1_clr", 32'(err_s[1]), 32'd0);
        idle(1);
        xfer(1, 1'b0, 1'b1, BASE + 32'd4, 4'hF, 32'h0, w, r);
        chk("t5_post_wait", 32'(w), 32'd3);
        chk("t5_no_write", r, 32'h12345678);

        // Read and write together: served as a read, write dropped.
        xfer(1, 1'b1, 1'b1, BASE + 32'd4, 4'hF, 32'hFFFFFFFF, w, r);
        chk("rw_wait", 32'(w), 32'd3);
        chk("rw_data", r, 32'h12345678);
        idle(1);
        chk("rw_err", 32'(err_s[1]), 32'd1);
        xfer(1, 1'b0, 1'b1, BASE + 32'd4, 4'hF, 32'h0, w, r);
        chk("rw_mem_kept", r, 32'h12345678);
        idle(1);

        // Random latency with scoreboard.
        ref_lfsr = 16'hACE1;
        seen0    = 1'b0;
        seen7    = 1'b0;
        for (int i = 0; i < NW; i++) begin
            d  = $urandom;
            ew = ref_wait();
            xfer(2, 1'b1, 1'b0, BASE + 32'(4 * i), 4'hF, d, w, r);
            chk("t6_pre_wait", 32'(w), 32'(ew));
            ref_mem[i] = d;
            if (w == 0) seen0 = 1'b1;
            if (w == 7) seen7 = 1'b1;
        end
        for (int n = 0; n < 500; n++) begin
            idx   = int'($urandom_range(NW - 1, 0));
            is_rd = 1'($urandom_range(1, 0));
            be    = 4'($urandom_range(15, 0));
            d     = $urandom;
            ew    = ref_wait();
            xfer(2, !is_rd, is_rd, BASE + 32'(4 * idx), be, d, w, r);
            chk("t6_wait", 32'(w), 32'(ew));
            chk("t6_range", 32'(w <= 7), 32'd1);
            if (w == 0) seen0 = 1'b1;
            if (w == 7) seen7 = 1'b1;
            if (is_rd) begin
                chk("t6_rdata", r, ref_mem[idx]);
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
                end
            end
            if ($urandom_range(3, 0) == 0) idle(1);
        end
        idle(1);
        chk("t6_seen0", 32'(seen0), 32'd1);
        chk("t6_seen7", 32'(seen7), 32'd1);
        chk("t6_err", 32'(err_s[2]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
